// File: rtl/gcn_pkg.sv
// Shared sizing, state encoding and helpers for the GCN result streamer.
package gcn_pkg;

  localparam int unsigned ROWS   = 100;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ROW_W  = 7;
  localparam int unsigned COL_W  = 3;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FILL   = 3'd1;
  localparam logic [2:0] HEADER = 3'd2;
  localparam logic [2:0] DATA1  = 3'd3;
  localparam logic [2:0] DATA2  = 3'd4;

  function automatic logic [DATA_W-1:0] pack_header(input logic [COL_W-1:0] col_2,
                                                    input logic [COL_W-1:0] col_1);
    return {{(8-COL_W){1'b0}}, col_2, {(8-COL_W){1'b0}}, col_1};
  endfunction

  function automatic logic [ROW_W-1:0] next_row(input logic [ROW_W-1:0] row);
    return (row == ROW_W'(ROWS - 1)) ? '0 : row + 1'b1;
  endfunction

endpackage

// File: rtl/gcn_col_buffer.sv
// One output column: ROWS x DATA_W storage, one write port, one registered read port.
module gcn_col_buffer
  import gcn_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ROW_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ROW_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [ROWS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Write-first bypass: the final write may target the row being prefetched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (we && (waddr == raddr)) begin
      rdata <= wdata;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/gcn_result_streamer.sv
// Captures two output columns and streams header + col1 + col2 onto the 16-bit bus.
// Optional build macro GCN_STREAMER_RELU_EN clamps negative data words to zero.
module gcn_result_streamer
  import gcn_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_valid,
  input  logic [ROW_W-1:0]  i_wr_row,
  input  logic [DATA_W-1:0] i_wr_data_1,
  input  logic [DATA_W-1:0] i_wr_data_2,
  input  logic [COL_W-1:0]  i_col_idx_1,
  input  logic [COL_W-1:0]  i_col_idx_2,
  input  logic              i_wr_last,
  input  logic              i_hold,
  output logic              o_busy,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_p,
  output logic              o_done,
  output logic              o_overrun
);

  logic [2:0]        state_q, state_d;
  logic [ROW_W-1:0]  cnt_q, cnt_d, raddr;
  logic [COL_W-1:0]  idx1_q, idx1_d, idx2_q, idx2_d;
  logic [DATA_W-1:0] p_d, rd1, rd2;
  logic              valid_d, done_d, busy_d, overrun_d;
  logic              streaming, wr_en;

  function automatic logic [DATA_W-1:0] clamp(input logic [DATA_W-1:0] w);
`ifdef GCN_STREAMER_RELU_EN
    return w[DATA_W-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  assign streaming = (state_q == HEADER) || (state_q == DATA1) || (state_q == DATA2);
  assign wr_en     = i_wr_valid && !streaming && (i_wr_row < ROW_W'(ROWS));

  gcn_col_buffer u_col1 (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (i_wr_row),
    .wdata (i_wr_data_1),
    .raddr (raddr),
    .rdata (rd1)
  );

  gcn_col_buffer u_col2 (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (i_wr_row),
    .wdata (i_wr_data_2),
    .raddr (raddr),
    .rdata (rd2)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx1_d    = idx1_q;
    idx2_d    = idx2_q;
    p_d       = o_p;
    valid_d   = o_valid;
    done_d    = 1'b0;
    overrun_d = i_wr_valid && streaming;
    case (state_q)
      IDLE, FILL: begin
        if (i_wr_valid) begin
          if (i_wr_last) begin
            state_d = HEADER;
            cnt_d   = '0;
            idx1_d  = i_col_idx_1;
            idx2_d  = i_col_idx_2;
            p_d     = pack_header(i_col_idx_2, i_col_idx_1);
            valid_d = 1'b1;
          end else begin
            state_d = FILL;
          end
        end
      end
      HEADER: begin
        if (!i_hold) begin
          state_d = DATA1;
          cnt_d   = '0;
          p_d     = clamp(rd1);
        end else begin
          p_d = pack_header(idx2_q, idx1_q);
        end
      end
      DATA1: begin
        if (!i_hold) begin
          if (cnt_q == ROW_W'(ROWS - 1)) begin
            state_d = DATA2;
            cnt_d   = '0;
            p_d     = clamp(rd2);
          end else begin
            cnt_d = cnt_q + 1'b1;
            p_d   = clamp(rd1);
          end
        end
      end
      DATA2: begin
        if (!i_hold) begin
          if (cnt_q == ROW_W'(ROWS - 1)) begin
            state_d = IDLE;
            cnt_d   = '0;
            p_d     = '0;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
            p_d   = clamp(rd2);
          end
        end
      end
      default: begin
        state_d = IDLE;
        p_d     = '0;
        valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
    // Prefetch the row that follows the word being loaded; re-reading it while held is harmless.
    raddr  = (state_d == HEADER) ? '0 : next_row(cnt_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx1_q    <= '0;
      idx2_q    <= '0;
      o_p       <= '0;
      o_valid   <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx1_q    <= idx1_d;
      idx2_q    <= idx2_d;
      o_p       <= p_d;
      o_valid   <= valid_d;
      o_busy    <= busy_d;
      o_done    <= done_d;
      o_overrun <= overrun_d;
    end
  end

endmodule
